// File: rtl/comp_ctrl_pkg.sv
// rtl/comp_ctrl_pkg.sv - shared types and constants for the compression job sequencer
package comp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_CAP   = 2'd1;
  localparam logic [1:0] CODE_TMO   = 2'd2;
  localparam logic [1:0] CODE_ABORT = 2'd3;

  // Operation bit positions inside the control word, also used by the datapath decode.
  localparam int DC_ENC = 5;
  localparam int DC_DEC = 6;

  // op/cap are {decode, encode}; exactly one op bit and the unit must support it.
  function automatic logic op_supported(input logic [1:0] op, input logic [1:0] cap);
    return ((op == 2'b01) || (op == 2'b10)) && ((op & cap) != 2'b00);
  endfunction

endpackage

// File: rtl/comp_job_cnt.sv
// rtl/comp_job_cnt.sv - saturating RUN cycle counter plus watchdog
module comp_job_cnt #(
  parameter int CNT_W = 32,
  parameter int TMO_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cycles,
  output logic             timeout
);

  // Timeout flags the RUN cycle that brings the watchdog to all-ones.
  localparam logic [TMO_W-1:0] WD_LAST = ~TMO_W'(1);

  logic [TMO_W-1:0] wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles <= '0;
      wd     <= '0;
    end else if (clr) begin
      cycles <= '0;
      wd     <= '0;
    end else if (inc) begin
      if (cycles != '1) cycles <= cycles + CNT_W'(1);
      wd <= wd + TMO_W'(1);
    end
  end

  assign timeout = (wd == WD_LAST);

endmodule

// File: rtl/comp_job_ctrl.sv
// rtl/comp_job_ctrl.sv - one-at-a-time job sequencer for the compression datapath
module comp_job_ctrl
  import comp_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int TMO_W      = 24,
  parameter int CNT_W      = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [23:0]      job_dc,
  input  logic             job_abort,
  input  logic [7:0]       m_cap,
  input  logic             m_endn,
  output logic             m_reset,
  output logic             m_enable,
  output logic [23:0]      dc,
  output logic             st_valid,
  input  logic             st_ready,
  output logic [1:0]       st_code,
  output logic [CNT_W-1:0] st_cycles,
  output logic             busy
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  state_t            state, state_next;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_next;
  logic [23:0]       dc_next;
  logic [1:0]        code_next;
  logic              cnt_clr, cnt_inc, timeout, accept;
  logic [1:0]        op, cap;

  logic unused_cap;
  assign unused_cap = ^{m_cap[7:DC_DEC+1], m_cap[DC_ENC-1:0]};

  assign op     = {job_dc[DC_DEC], job_dc[DC_ENC]};
  assign cap    = {m_cap[DC_DEC], m_cap[DC_ENC]};
  assign accept = job_valid && job_ready && (state == ST_IDLE);

  comp_job_cnt #(
    .CNT_W(CNT_W),
    .TMO_W(TMO_W)
  ) u_cnt (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cycles (st_cycles),
    .timeout(timeout)
  );

  always_comb begin
    state_next   = state;
    rst_cnt_next = rst_cnt;
    dc_next      = dc;
    code_next    = st_code;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          dc_next      = job_dc;
          cnt_clr      = 1'b1;
          rst_cnt_next = '0;
          if (op_supported(op, cap)) begin
            state_next = ST_RST;
          end else begin
            state_next = ST_REPORT;
            code_next  = CODE_CAP;
          end
        end
      end
      ST_RST: begin
        if (job_abort) begin
          state_next = ST_DRAIN;
          code_next  = CODE_ABORT;
        end else if (rst_cnt == RC_LAST) begin
          state_next = ST_RUN;
        end else begin
          rst_cnt_next = rst_cnt + RC_W'(1);
        end
      end
      ST_RUN: begin
        // The exit cycle is still a RUN cycle, so it is counted too.
        cnt_inc = 1'b1;
        if (job_abort) begin
          state_next = ST_DRAIN;
          code_next  = CODE_ABORT;
        end else if (!m_endn) begin
          state_next = ST_DRAIN;
          code_next  = CODE_OK;
        end else if (timeout) begin
          state_next = ST_DRAIN;
          code_next  = CODE_TMO;
        end
      end
      ST_DRAIN: state_next = ST_REPORT;
      ST_REPORT: begin
        if (st_ready) begin
          state_next = ST_IDLE;
          dc_next    = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      rst_cnt   <= '0;
      dc        <= '0;
      st_code   <= CODE_OK;
      m_reset   <= 1'b1;
      m_enable  <= 1'b0;
      job_ready <= 1'b0;
      st_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      rst_cnt   <= rst_cnt_next;
      dc        <= dc_next;
      st_code   <= code_next;
      m_reset   <= (state_next == ST_RST) || (state_next == ST_DRAIN);
      m_enable  <= (state_next == ST_RUN);
      job_ready <= (state_next == ST_IDLE);
      st_valid  <= (state_next == ST_REPORT);
      busy      <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_comp_job_ctrl.sv
// tb/tb_comp_job_ctrl.sv - self-checking bench for comp_job_ctrl
module tb_comp_job_ctrl;

  localparam int RSTC   = 4;
  localparam int TMOMAX = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready, job_abort, m_endn, m_reset, m_enable;
  logic        st_valid, st_ready, busy;
  logic [23:0] job_dc, dc;
  logic [7:0]  m_cap;
  logic [1:0]  st_code;
  logic [7:0]  st_cycles;

  int ncmp  = 0;
  int nfail = 0;

  comp_job_ctrl #(
    .RST_CYCLES(RSTC),
    .TMO_W     (4),
    .CNT_W     (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_dc   (job_dc),
    .job_abort(job_abort),
    .m_cap    (m_cap),
    .m_endn   (m_endn),
    .m_reset  (m_reset),
    .m_enable (m_enable),
    .dc       (dc),
    .st_valid (st_valid),
    .st_ready (st_ready),
    .st_code  (st_code),
    .st_cycles(st_cycles),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // d: RUN cycle whose end sees m_endn low; k: cycle after accept carrying job_abort (0 = none).
  task automatic run_job(input logic [23:0] jdc, input logic [7:0] cap, input int d, input int k,
                         input int hold, input bit offer_next, input logic [23:0] next_dc);
    int ecode, ecyc, erst, een, elat, r, waitc, tval, nrst, nen;
    bit done;
    logic [1:0] op, cp;
    op = {jdc[6], jdc[5]};
    cp = {cap[6], cap[5]};
    if (!((op == 2'b01 || op == 2'b10) && ((op & cp) != 2'b00))) begin
      ecode = 1; ecyc = 0; erst = 0; een = 0; elat = 1;
    end else if (k >= 1 && k <= RSTC) begin
      ecode = 3; ecyc = 0; erst = k + 1; een = 0; elat = k + 2;
    end else begin
      r = 0; done = 0; ecode = 0;
      while (!done) begin
        r++;
        if (k == RSTC + r)  begin ecode = 3; done = 1; end
        else if (r >= d)    begin ecode = 0; done = 1; end
        else if (r == TMOMAX) begin ecode = 2; done = 1; end
      end
      ecyc = r; erst = RSTC + 1; een = r; elat = RSTC + r + 2;
    end

    waitc = 0;
    while (!job_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_job", 32'(job_ready), 32'd1);
    job_valid = 1'b1; job_dc = jdc; m_cap = cap; m_endn = 1'b1; job_abort = 1'b0;
    @(negedge clk);
    job_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);

    tval = 0; nrst = 0; nen = 0;
    for (int t = 1; t <= 40; t++) begin
      if (st_valid) begin
        tval = t;
        break;
      end
      nrst += int'(m_reset);
      nen  += int'(m_enable);
      job_abort = (t == k);
      m_endn    = !(t >= RSTC + d);
      @(negedge clk);
    end
    job_abort = 1'b0; m_endn = 1'b1;

    check("st_valid_latency", 32'(tval), 32'(elat));
    check("st_code", 32'(st_code), 32'(ecode));
    check("st_cycles", 32'(st_cycles), 32'(ecyc));
    check("m_reset_cycles", 32'(nrst), 32'(erst));
    check("m_enable_cycles", 32'(nen), 32'(een));
    check("dc_in_report", 32'(dc), 32'(jdc));
    check("ready_in_report", 32'(job_ready), 32'd0);

    if (offer_next) begin
      job_valid = 1'b1;
      job_dc    = next_dc;
    end
    for (int h = 0; h < hold; h++) begin
      st_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(st_valid), 32'd1);
      check("hold_code", 32'(st_code), 32'(ecode));
      check("hold_cycles", 32'(st_cycles), 32'(ecyc));
      check("hold_ready", 32'(job_ready), 32'd0);
      check("hold_dc", 32'(dc), 32'(jdc));
    end
    st_ready = 1'b1;
    @(negedge clk);
    st_ready = 1'b0;
    check("post_hs_valid", 32'(st_valid), 32'd0);
    check("post_hs_dc", 32'(dc), 32'd0);
    check("post_hs_ready", 32'(job_ready), 32'd1);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [23:0] rdc;
    logic [7:0]  rcap;
    int rd, rk;

    rst = 1'b1; job_valid = 1'b0; job_dc = '0; job_abort = 1'b0;
    m_cap = '0; m_endn = 1'b1; st_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_m_reset", 32'(m_reset), 32'd1);
    check("rst_m_enable", 32'(m_enable), 32'd0);
    check("rst_job_ready", 32'(job_ready), 32'd0);
    check("rst_dc", 32'(dc), 32'd0);
    check("rst_st_valid", 32'(st_valid), 32'd0);
    check("rst_st_code", 32'(st_code), 32'd0);
    check("rst_st_cycles", 32'(st_cycles), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_m_reset", 32'(m_reset), 32'd0);
    check("rel_job_ready", 32'(job_ready), 32'd1);

    run_job(24'h000020, 8'h60, 10, 0, 0, 1'b0, 24'h0);
    run_job(24'h000060, 8'h60, 5, 0, 0, 1'b0, 24'h0);
    run_job(24'h000040, 8'h20, 5, 0, 0, 1'b0, 24'h0);
    run_job(24'h000020, 8'h60, 100, 0, 1, 1'b0, 24'h0);
    run_job(24'h000040, 8'h40, 3, RSTC + 3, 0, 1'b0, 24'h0);
    run_job(24'h000020, 8'h20, 3, 2, 0, 1'b0, 24'h0);
    run_job(24'h000020, 8'h20, 4, 0, 5, 1'b1, 24'h000040);
    run_job(24'h000040, 8'h60, 6, 0, 0, 1'b0, 24'h0);

    // Reset in the middle of RUN.
    job_valid = 1'b1; job_dc = 24'h000020; m_cap = 8'h60;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_run_enable", 32'(m_enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_m_reset", 32'(m_reset), 32'd1);
    check("async_m_enable", 32'(m_enable), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_dc", 32'(dc), 32'd0);
    check("async_st_cycles", 32'(st_cycles), 32'd0);
    @(negedge clk);
    check("rst_hold_st_valid", 32'(st_valid), 32'd0);
    check("rst_hold_m_reset", 32'(m_reset), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rerel_job_ready", 32'(job_ready), 32'd1);
    check("rerel_st_valid", 32'(st_valid), 32'd0);
    run_job(24'h000020, 8'h20, 7, 0, 0, 1'b0, 24'h0);

    for (int i = 0; i < 40; i++) begin
      rdc  = 24'($urandom);
      rcap = 8'($urandom);
      rd   = int'($urandom_range(1, 20));
      rk   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 22));
      run_job(rdc, rcap, rd, rk, int'($urandom_range(0, 3)), 1'b0, 24'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
